// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/uart_tx handshake bundle for the round-robin byte-stream arbiter.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
);
  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [PORTS-1:0]            s_axis_tvalid;
  logic [PORTS-1:0]            s_axis_tlast;
  logic [PORTS-1:0]            s_axis_tready;
  logic [PORTS-1:0]            enable;
  logic [DATA_WIDTH-1:0]       m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic [PORTS-1:0]            grant;
  logic [3:0]                  grant_index;
  logic                        busy;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, enable, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, grant, grant_index, busy
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, enable, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, grant, grant_index, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter feeding one uart_tx byte stream.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module uart_tx_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int HEADER_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t                  state_q;
  logic [PORTS-1:0]        grant_q;
  logic [3:0]              grant_index_q;
  logic                    m_tvalid_q;
  logic [DATA_WIDTH-1:0]   m_tdata_q;

  logic [PORTS-1:0]        req;
  logic [PORTS-1:0]        win_oh;
  logic [3:0]              win_idx;
  logic                    found;
  logic                    load_ok;
  logic [PORTS-1:0]        s_tready;
  logic [PORTS-1:0]        hs;
  logic                    hs_any;
  logic                    hs_last;
  logic [DATA_WIDTH-1:0]   g_data;

  assign req     = bus.s_axis_tvalid & bus.enable;
  assign load_ok = !m_tvalid_q || bus.m_axis_tready;
  assign s_tready = (state_q == DATA && load_ok) ? grant_q : '0;
  assign hs      = bus.s_axis_tvalid & s_tready;
  assign hs_any  = |hs;
  assign hs_last = |(hs & bus.s_axis_tlast);

  // Two passes give a search starting just above the last grant and wrapping to 0.
  always_comb begin
    win_oh  = '0;
    win_idx = grant_index_q;
    found   = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (!found && req[i] && i > int'(grant_index_q)) begin
        win_oh[i] = 1'b1;
        win_idx   = 4'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < PORTS; i++) begin
      if (!found && req[i] && i <= int'(grant_index_q)) begin
        win_oh[i] = 1'b1;
        win_idx   = 4'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q[i]) begin
        g_data = g_data | bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_index_q <= 4'(PORTS - 1);
      m_tvalid_q    <= 1'b0;
      m_tdata_q     <= '0;
    end else begin
      if (m_tvalid_q && bus.m_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q       <= win_oh;
            grant_index_q <= win_idx;
            state_q       <= (HEADER_EN != 0) ? HEADER : DATA;
          end
        end
        HEADER: begin
          if (load_ok) begin
            m_tdata_q  <= DATA_WIDTH'(grant_index_q);
            m_tvalid_q <= 1'b1;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (hs_any) begin
            m_tdata_q  <= g_data;
            m_tvalid_q <= 1'b1;
            if (hs_last) begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_axis_tready = s_tready;
  assign bus.m_axis_tdata  = m_tdata_q;
  assign bus.m_axis_tvalid = m_tvalid_q;
  assign bus.grant         = grant_q;
  assign bus.grant_index   = grant_index_q;
  assign bus.busy          = (state_q != IDLE) || m_tvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for the round-robin uart_tx arbiter.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;
  localparam int PORTS = 4;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.PORTS(PORTS), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .HEADER_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]       src_q[PORTS][$];
  logic [7:0]       out_q[$];
  int               out_cyc[$];
  logic [7:0]       exp_q[$];
  logic [PORTS-1:0] hs_pend = '0;
  logic [PORTS-1:0] gate = '0;
  logic             bp_mode = 1'b0;
  logic [3:0]       bp_pat = 4'b1001;
  int               cyc = 0;
  int               s_hs_cnt[PORTS];
  int               stab_viol = 0;
  int               stall_rdy_viol = 0;
  int               stall_cnt = 0;
  int               rdy2_cnt = 0;
  int               gnt2_cnt = 0;
  logic             prev_stall = 1'b0;
  logic [7:0]       prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Source driver: pops accepted beats and presents the next one after each edge.
  initial begin
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < PORTS; i++) begin
        if (hs_pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && !gate[i]) begin
          bus.s_axis_tvalid[i]        = 1'b1;
          bus.s_axis_tdata[i*DW +: DW] = src_q[i][0][7:0];
          bus.s_axis_tlast[i]         = src_q[i][0][8];
        end else begin
          bus.s_axis_tvalid[i]        = 1'b0;
          bus.s_axis_tdata[i*DW +: DW] = '0;
          bus.s_axis_tlast[i]         = 1'b0;
        end
      end
      bus.m_axis_tready = bp_mode ? bp_pat[cyc[1:0]] : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      hs_pend = bus.s_axis_tvalid & bus.s_axis_tready;
      for (int i = 0; i < PORTS; i++) if (hs_pend[i]) s_hs_cnt[i]++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        out_q.push_back(bus.m_axis_tdata);
        out_cyc.push_back(cyc);
      end
      if (prev_stall && (!bus.m_axis_tvalid || bus.m_axis_tdata != prev_data)) stab_viol++;
      if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
        stall_cnt++;
        if (bus.s_axis_tready != '0) stall_rdy_viol++;
      end
      if (bus.s_axis_tready[2]) rdy2_cnt++;
      if (bus.grant[2]) gnt2_cnt++;
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_data  = bus.m_axis_tdata;
      cyc++;
    end
  end

  task automatic do_reset();
    rst         = 1'b1;
    gate        = '0;
    bp_mode     = 1'b0;
    bus.enable  = '1;
    for (int i = 0; i < PORTS; i++) src_q[i].delete();
    tick();
    tick();
    rst = 1'b0;
    out_q.delete();
    out_cyc.delete();
    for (int i = 0; i < PORTS; i++) s_hs_cnt[i] = 0;
    stab_viol = 0; stall_rdy_viol = 0; stall_cnt = 0;
    rdy2_cnt = 0; gnt2_cnt = 0; prev_stall = 1'b0;
  endtask

  task automatic push(input int port, input logic [7:0] data, input logic last);
    src_q[port].push_back({last, data});
  endtask

  task automatic check_seq(input string name);
    int k = 0;
    while (out_q.size() < exp_q.size() && k < 300) begin
      tick();
      k++;
    end
    for (int j = 0; j < exp_q.size(); j++) begin
      check($sformatf("%s byte%0d", name, j),
            (j < out_q.size()) ? {24'd0, out_q[j]} : 32'hDEAD_BEEF, {24'd0, exp_q[j]});
    end
  endtask

  function automatic int cyc_at(input int k);
    return (k < out_cyc.size()) ? out_cyc[k] : -100;
  endfunction

  initial begin
    bus.enable = '1;
    for (int i = 0; i < PORTS; i++) s_hs_cnt[i] = 0;

    // Reset state
    do_reset();
    check("rst m_tvalid", 32'(bus.m_axis_tvalid), 0);
    check("rst m_tdata", 32'(bus.m_axis_tdata), 0);
    check("rst grant", 32'(bus.grant), 0);
    check("rst grant_index", 32'(bus.grant_index), 3);
    check("rst busy", 32'(bus.busy), 0);
    check("rst s_tready", 32'(bus.s_axis_tready), 0);

    // Single packet from port 2
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    for (int k = 0; k < 20 && out_q.size() < 1; k++) tick();
    check("t1 grant mid", 32'(bus.grant), 32'b0100);
    check("t1 busy mid", 32'(bus.busy), 1);
    exp_q = '{8'h02, 8'h41, 8'h42, 8'h43};
    check_seq("t1");
    tick(); tick();
    check("t1 grant after", 32'(bus.grant), 0);
    check("t1 grant_index", 32'(bus.grant_index), 2);
    check("t1 busy after", 32'(bus.busy), 0);

    // All four ports at once
    do_reset();
    for (int p = 0; p < PORTS; p++) begin
      push(p, 8'hA0 + 8'(p*16), 1'b0);
      push(p, 8'hA1 + 8'(p*16), 1'b1);
    end
    exp_q = '{8'h00, 8'hA0, 8'hA1, 8'h01, 8'hB0, 8'hB1,
              8'h02, 8'hC0, 8'hC1, 8'h03, 8'hD0, 8'hD1};
    check_seq("t2");
    for (int k = 1; k < 4; k++) begin
      check($sformatf("t2 gap%0d", k), 32'(cyc_at(3*k) - cyc_at(3*k-1)), 2);
    end
    check("t2 in-packet spacing", 32'(cyc_at(5) - cyc_at(3)), 2);

    // Backpressure on port 1
    do_reset();
    bp_mode = 1'b1;
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b0); push(1, 8'h54, 1'b1);
    exp_q = '{8'h01, 8'h51, 8'h52, 8'h53, 8'h54};
    check_seq("t3");
    check("t3 stalls seen", 32'(stall_cnt > 0), 1);
    check("t3 tdata stable", 32'(stab_viol), 0);
    check("t3 s_tready on stall", 32'(stall_rdy_viol), 0);

    // Port 0 pauses mid-packet while port 3 waits
    do_reset();
    push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b0); push(0, 8'h63, 1'b1);
    push(3, 8'h71, 1'b1);
    for (int k = 0; k < 20 && s_hs_cnt[0] < 1; k++) tick();
    gate[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t4 grant hold%0d", k), 32'(bus.grant), 32'b0001);
    end
    gate[0] = 1'b0;
    exp_q = '{8'h00, 8'h61, 8'h62, 8'h63, 8'h03, 8'h71};
    check_seq("t4");

    // Port 2 masked off
    do_reset();
    bus.enable = 4'b1011;
    push(0, 8'h81, 1'b1); push(0, 8'h82, 1'b1);
    push(1, 8'h91, 1'b1);
    push(2, 8'hA1, 1'b1);
    push(3, 8'hB1, 1'b1);
    exp_q = '{8'h00, 8'h81, 8'h01, 8'h91, 8'h03, 8'hB1, 8'h00, 8'h82};
    check_seq("t5");
    for (int k = 0; k < 10; k++) tick();
    check("t5 no extra bytes", 32'(out_q.size()), 8);
    check("t5 s_tready2 never", 32'(rdy2_cnt), 0);
    check("t5 grant2 never", 32'(gnt2_cnt), 0);

    // Reset mid-packet, then a fresh request
    do_reset();
    push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b0); push(0, 8'hC3, 1'b0); push(0, 8'hC4, 1'b1);
    for (int k = 0; k < 30 && s_hs_cnt[0] < 2; k++) tick();
    tick();
    rst = 1'b1;
    src_q[0].delete();
    tick();
    rst = 1'b0;
    check("t6 m_tvalid", 32'(bus.m_axis_tvalid), 0);
    check("t6 grant", 32'(bus.grant), 0);
    check("t6 busy", 32'(bus.busy), 0);
    check("t6 grant_index", 32'(bus.grant_index), 3);
    out_q.delete();
    out_cyc.delete();
    push(1, 8'hD1, 1'b0); push(1, 8'hD2, 1'b1);
    exp_q = '{8'h01, 8'hD1, 8'hD2};
    check_seq("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin packet arbiter that shares one uart_tx byte stream between PORTS AXI-Stream requesters. A grant is held from the first byte of a packet through its tlast beat, so packets from different sources never interleave on the serial line. An optional one-byte source-ID header is sent ahead of each packet. The output sits between the requesters and the uart_tx s_axis input.

Parameters:
PORTS, 4, number of requesters (2..16)
DATA_WIDTH, 8, byte width; must match uart_tx DATA_WIDTH
HEADER_EN, 1, 1 = emit source-index header byte before each packet; 0 = no header

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous and active-high
s_axis_tdata  input  PORTS*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  input  PORTS  per-port valid
s_axis_tlast  input  PORTS  per-port end of packet
s_axis_tready  output  PORTS  per-port ready
enable  input  PORTS  per-port arbitration enable mask
m_axis_tdata  output  DATA_WIDTH  to uart_tx s_axis_tdata
m_axis_tvalid  output  1  to uart_tx s_axis_tvalid
m_axis_tready  input  1  from uart_tx s_axis_tready
grant  output  PORTS  one-hot current grant; 0 when idle
grant_index  output  4  index of the granted port; last-granted index held while idle
busy  output  1  high in HEADER or DATA state, or while m_axis_tvalid is high

Behaviour:
- Reset values: all s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, grant=0, grant_index=PORTS-1, busy=0, state=IDLE. Rst is sampled every cycle; reset mid-packet drops the output register contents and any partial packet.
- Output register: one stage. The register loads whenever it is empty or m_axis_tready=1 in the same cycle. m_axis_tvalid and m_axis_tdata are registered with no combinational path from the s_axis inputs.
- s_axis_tready[i] = (state==DATA) && grant[i] && (!m_axis_tvalid || m_axis_tready). Combinational; 0 for all ungranted ports.
- Request for port i = s_axis_tvalid[i] && enable[i].
- IDLE:
  - No requests: stay in IDLE.
  - Otherwise the winner is the first requesting port searching upward from grant_index+1, modulo PORTS.
  - On the next edge: grant and grant_index are set, and state goes to HEADER if HEADER_EN=1, else DATA.
- HEADER: when the output register can load, load tdata = grant_index zero-extended, then go to DATA.
- DATA:
  - Each s_axis handshake on the granted port loads that byte into the output register.
  - A handshake with tlast=1 returns the state to IDLE and clears grant; grant_index keeps its value.
- Latency: from request first seen in IDLE to the first m_axis_tvalid:
  - HEADER_EN=1: 2 cycles; header appears first, the data byte 1 cycle later if m_axis_tready allows.
  - HEADER_EN=0: 2 cycles.
- Packet gap: at least one IDLE cycle between packets, so back-to-back packets have a 1-cycle arbitration bubble.
- Grant hold rules:
  - Deasserting enable[g] or s_axis_tvalid[g] mid-packet does not revoke the grant. The arbiter waits indefinitely for tlast.
  - A single-beat packet (tlast on the first byte) is legal.
- Fairness: with all ports continuously requesting, grants rotate 0,1,2,3,0,... After reset the first search starts at port 0.
- m_axis_tvalid, once asserted, stays high with stable tdata until m_axis_tready=1 (AXI rule).
- Ports with enable=0 are never granted and see tready=0.

Test Plan:
- HEADER_EN=1. Port 2 sends 3 bytes 0x41,0x42,0x43 (tlast on 0x43), m_axis_tready held at 1:
  - m_axis carries 0x02,0x41,0x42,0x43.
  - grant=4'b0100 during the packet, then 0.
  - grant_index stays 2.
- All 4 ports request 2-byte packets at the same time:
  - Headers arrive in the order 0x00,0x01,0x02,0x03.
  - No byte interleaving between packets.
  - Exactly one idle cycle between packets.
- Backpressure: m_axis_tready toggles 1,0,0,1,... during a port-1 packet:
  - m_axis_tdata stays stable while valid && !ready.
  - s_axis_tready[1] is low on the stall cycles.
  - The byte sequence is intact.
- Port 0 drops tvalid for 5 cycles mid-packet while port 3 requests:
  - grant stays 4'b0001.
  - Port 3 is served only after port 0's tlast.
- enable=4'b1011 with all ports requesting:
  - Port 2 is never granted and s_axis_tready[2] stays 0.
  - Rotation is 0,1,3,0.
- Assert rst for 1 cycle mid-packet (after the 2nd byte):
  - Next cycle: m_axis_tvalid=0, grant=0, busy=0, grant_index=3.
  - A fresh request on port 1 is granted normally with header 0x01.
